load_store_unit: RTL and testbench
==================================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TAG_W, default 5: width of the destination-register tag carried with each request.
REQ-002 clk  in  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 req_valid  in  1  execute stage presents a memory operation.
REQ-005 req_ready  out  1  unit can accept a request; 1 only in IDLE.
REQ-006 is_store  in  1  1 means store, 0 means load.
REQ-007 funct3  in  3  RV32I width code: LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101.
REQ-008 addr  in  32  effective byte address, taken from the ALU sum output.
REQ-009 wdata  in  32  store data (rs2).
REQ-010 tag_in  in  TAG_W  destination register tag.
REQ-011 mem_req  out  1  memory request, held until granted.
REQ-012 mem_we  out  1  write strobe.
REQ-013 mem_addr  out  32  word address: addr with bits [1:0] forced to 0.
REQ-014 mem_be  out  4  byte enables.
REQ-015 mem_wdata  out  32  lane-replicated store data.
REQ-016 mem_gnt  in  1  memory accepts the request this cycle.
REQ-017 mem_rvalid  in  1  read data valid.
REQ-018 mem_rdata  in  32  read word.
REQ-019 resp_valid  out  1  one-cycle completion pulse.
REQ-020 resp_data  out  32  extended load result; 0 for stores and faults.
REQ-021 resp_tag  out  TAG_W  tag of the completing operation.
REQ-022 fault  out  1  qualifies resp_valid; 1 means the access was misaligned or illegal.

Function
REQ-023 Acceptance occurs when req_valid and req_ready are both 1. At acceptance the unit SHALL latch is_store, funct3, addr, wdata and tag_in.
REQ-024 States SHALL be IDLE, REQ and WAIT.
- IDLE to REQ: on an accepted, legal access.
- REQ to IDLE: on mem_gnt for a store.
- REQ to WAIT: on mem_gnt for a load.
- WAIT to IDLE: on mem_rvalid.
REQ-025 mem_req SHALL be 1 exactly while in REQ. mem_addr, mem_be, mem_we and mem_wdata SHALL be stable while in REQ.
REQ-026 Byte enables SHALL be:
- byte access: 1<<addr[1:0].
- half access: 0011 when addr[1]=0, 1100 when addr[1]=1.
- word access: 1111.
Loads drive the same mask.
REQ-027 mem_wdata SHALL be:
- SB: byte replicated 4 times.
- SH: halfword replicated 2 times.
- SW: wdata unchanged.
REQ-028 Load result SHALL be mem_rdata shifted right by 8*addr[1:0]. LB/LH SHALL sign-extend; LBU/LHU SHALL zero-extend; LW SHALL pass the word unchanged.
REQ-029 Misaligned or illegal accesses SHALL fault. These are:
- half access with addr[0]=1.
- word access with addr[1:0]!=0.
- funct3 011, 110 or 111.
- a store with funct3[2]=1.
For a fault: no mem_req is issued, the state stays IDLE, and the next cycle gives resp_valid=1, fault=1, resp_data=0.
REQ-030 resp_valid SHALL pulse 1 cycle after the completing event: mem_gnt for a store, mem_rvalid for a load. It SHALL be a single-cycle pulse, with no backpressure.
REQ-031 In REQ, if a load sees mem_gnt and mem_rvalid in the same cycle, it SHALL complete directly to IDLE.
REQ-032 mem_rvalid SHALL be ignored in IDLE, and ignored in REQ unless mem_gnt is also 1.
REQ-033 Minimum latency:
- load: accept c0, mem_req c1, gnt c1, rvalid c2, resp_valid c3.
- store: accept c0, gnt c1, resp_valid c2.

Reset
REQ-034 While rst_n=0 the unit SHALL hold state=IDLE and drive all outputs to 0. This includes req_ready=0 during reset; req_ready becomes 1 on the first clock after release.
REQ-035 Reset asserted mid-operation SHALL abandon the access; a stale mem_rvalid after release SHALL produce no response.

Structure
REQ-036 The funct3 width codes and the state encoding SHALL live in shared package riscv_pkg.
REQ-037 Load extraction and extension SHALL be a combinational sub-module, lsu_load_align.

Verification
REQ-038 Accept SB with addr=0x1003, wdata=0xA5, gnt on the first cycle. Required: mem_addr=0x1000, mem_be=1000, mem_wdata=0xA5A5A5A5, resp_valid 2 cycles after acceptance.
REQ-039 Accept LB with addr=0x2001, rdata=0x0000_8000. Required: resp_data=0xFFFFFF80. The same access as LBU returns 0x00000080.
REQ-040 Accept LW with addr=0x3002. Required: no mem_req, and 1 cycle later resp_valid=1, fault=1, resp_data=0.
REQ-041 Accept LH with mem_gnt held low for 4 cycles. Required: mem_req and address stable for all 4 cycles, req_ready=0 throughout.
REQ-042 Deassert rst_n while in WAIT, release it, then pulse mem_rvalid. Required: no resp_valid, and req_ready=1 on the first clock after release.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I load/store definitions: funct3 width codes, LSU state encoding
// and the pure helpers for byte-enable, store-lane and legality decode.
package riscv_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } lsu_state_e;

    // funct3[1:0] encodes the access size: 00 byte, 01 half, 10 word.
    function automatic logic [3:0] lsu_byte_en(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] be;
        case (f3[1:0])
            2'b00:   be = 4'b0001 << off;
            2'b01:   be = off[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic [31:0] lsu_store_data(input logic [2:0] f3, input logic [31:0] wd);
        logic [31:0] d;
        case (f3[1:0])
            2'b00:   d = {4{wd[7:0]}};
            2'b01:   d = {2{wd[15:0]}};
            default: d = wd;
        endcase
        return d;
    endfunction

    function automatic logic lsu_illegal(input logic st, input logic [2:0] f3, input logic [1:0] off);
        logic bad;
        case (f3)
            F3_B, F3_BU: bad = 1'b0;
            F3_H, F3_HU: bad = off[0];
            F3_W:        bad = (off != 2'b00);
            default:     bad = 1'b1;
        endcase
        if (st && f3[2]) begin
            bad = 1'b1;
        end
        return bad;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load extraction: shifts the read word down to the addressed
// lane and sign- or zero-extends according to funct3.
module lsu_load_align
    import riscv_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] data
);

    logic [31:0] shifted;

    assign shifted = rdata >> {offset, 3'b000};

    // Word loads are only legal at offset 0, so the shifted word equals rdata.
    always_comb begin
        data = 32'h0;
        case (funct3)
            F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
            F3_W:    data = shifted;
            F3_BU:   data = {24'h0, shifted[7:0]};
            F3_HU:   data = {16'h0, shifted[15:0]};
            default: data = 32'h0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding RV32I load/store unit: IDLE -> REQ -> (WAIT) -> IDLE,
// with misaligned/illegal accesses answered by a fault pulse without a bus request.
module load_store_unit
    import riscv_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             is_store,
    input  logic [2:0]       funct3,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    input  logic [TAG_W-1:0] tag_in,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [3:0]       mem_be,
    output logic [31:0]      mem_wdata,
    input  logic             mem_gnt,
    input  logic             mem_rvalid,
    input  logic [31:0]      mem_rdata,
    output logic             resp_valid,
    output logic [31:0]      resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic             fault
);

    lsu_state_e       state_q, state_d;
    logic             run_q;
    logic             store_q;
    logic [2:0]       f3_q;
    logic [31:0]      addr_q;
    logic [31:0]      wdata_q;
    logic [TAG_W-1:0] tag_q;

    logic             resp_valid_q, resp_valid_d;
    logic             fault_q, fault_d;
    logic [31:0]      resp_data_q, resp_data_d;
    logic [TAG_W-1:0] resp_tag_q, resp_tag_d;

    logic             accept;
    logic             illegal;
    logic [31:0]      load_data;

    // run_q keeps req_ready low while in reset and for the release cycle itself.
    assign req_ready = run_q && (state_q == ST_IDLE);
    assign accept    = req_valid && req_ready;
    assign illegal   = lsu_illegal(is_store, funct3, addr[1:0]);

    assign mem_req   = (state_q == ST_REQ);
    assign mem_we    = (state_q == ST_REQ) && store_q;
    assign mem_addr  = {addr_q[31:2], 2'b00};
    assign mem_be    = lsu_byte_en(f3_q, addr_q[1:0]);
    assign mem_wdata = lsu_store_data(f3_q, wdata_q);

    assign resp_valid = resp_valid_q;
    assign fault      = fault_q;
    assign resp_data  = resp_data_q;
    assign resp_tag   = resp_tag_q;

    lsu_load_align u_align (
        .rdata  (mem_rdata),
        .offset (addr_q[1:0]),
        .funct3 (f3_q),
        .data   (load_data)
    );

    always_comb begin
        state_d      = state_q;
        resp_valid_d = 1'b0;
        fault_d      = 1'b0;
        resp_data_d  = 32'h0;
        resp_tag_d   = resp_tag_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (illegal) begin
                        resp_valid_d = 1'b1;
                        fault_d      = 1'b1;
                        resp_tag_d   = tag_in;
                    end else begin
                        state_d = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (mem_gnt) begin
                    if (store_q) begin
                        state_d      = ST_IDLE;
                        resp_valid_d = 1'b1;
                        resp_tag_d   = tag_q;
                    end else if (mem_rvalid) begin
                        state_d      = ST_IDLE;
                        resp_valid_d = 1'b1;
                        resp_data_d  = load_data;
                        resp_tag_d   = tag_q;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    state_d      = ST_IDLE;
                    resp_valid_d = 1'b1;
                    resp_data_d  = load_data;
                    resp_tag_d   = tag_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            run_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            fault_q      <= 1'b0;
            resp_data_q  <= 32'h0;
            resp_tag_q   <= '0;
        end else begin
            state_q      <= state_d;
            run_q        <= 1'b1;
            resp_valid_q <= resp_valid_d;
            fault_q      <= fault_d;
            resp_data_q  <= resp_data_d;
            resp_tag_q   <= resp_tag_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            store_q <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            tag_q   <= '0;
        end else if (accept) begin
            store_q <= is_store;
            f3_q    <= funct3;
            addr_q  <= addr;
            wdata_q <= wdata;
            tag_q   <= tag_in;
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: hand-computed vectors for stores, loads,
// faults, grant stalls and reset in the middle of a load.
module tb_load_store_unit;

    localparam int TAG_W = 5;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             req_valid;
    logic             req_ready;
    logic             is_store;
    logic [2:0]       funct3;
    logic [31:0]      addr;
    logic [31:0]      wdata;
    logic [TAG_W-1:0] tag_in;
    logic             mem_req;
    logic             mem_we;
    logic [31:0]      mem_addr;
    logic [3:0]       mem_be;
    logic [31:0]      mem_wdata;
    logic             mem_gnt;
    logic             mem_rvalid;
    logic [31:0]      mem_rdata;
    logic             resp_valid;
    logic [31:0]      resp_data;
    logic [TAG_W-1:0] resp_tag;
    logic             fault;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    load_store_unit #(.TAG_W(TAG_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .is_store   (is_store),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .tag_in     (tag_in),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_tag   (resp_tag),
        .fault      (fault)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single cycle; returns one cycle after the accepting edge.
    task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [TAG_W-1:0] t);
        check("ready_before_issue", {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1;
        is_store  = st;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        tag_in    = t;
        cyc();
        req_valid = 1'b0;
        $display("txn: %s f3=%b addr=%h wdata=%h tag=%0d", st ? "store" : "load", f3, a, wd, t);
    endtask

    initial begin
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        is_store   = 1'b0;
        funct3     = 3'b000;
        addr       = 32'h0;
        wdata      = 32'h0;
        tag_in     = '0;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;

        // Reset state
        #13;
        check("rst_ready", {31'h0, req_ready}, 32'h0);
        check("rst_mem_req", {31'h0, mem_req}, 32'h0);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        rst_n = 1'b1;
        cyc();
        check("ready_after_release", {31'h0, req_ready}, 32'h1);

        // SB at 0x1003, granted on first REQ cycle
        issue(1'b1, 3'b000, 32'h0000_1003, 32'h0000_00A5, 5'd3);
        check("sb_mem_req", {31'h0, mem_req}, 32'h1);
        check("sb_mem_we", {31'h0, mem_we}, 32'h1);
        check("sb_mem_addr", mem_addr, 32'h0000_1000);
        check("sb_mem_be", {28'h0, mem_be}, 32'h8);
        check("sb_mem_wdata", mem_wdata, 32'hA5A5_A5A5);
        check("sb_ready_busy", {31'h0, req_ready}, 32'h0);
        mem_gnt = 1'b1;
        cyc();
        mem_gnt = 1'b0;
        check("sb_resp_valid", {31'h0, resp_valid}, 32'h1);
        check("sb_fault", {31'h0, fault}, 32'h0);
        check("sb_resp_data", resp_data, 32'h0);
        check("sb_resp_tag", {27'h0, resp_tag}, 32'd3);
        check("sb_mem_req_drop", {31'h0, mem_req}, 32'h0);
        cyc();
        check("sb_pulse_one_cycle", {31'h0, resp_valid}, 32'h0);

        // LB at 0x2001, rvalid one cycle after grant
        issue(1'b0, 3'b000, 32'h0000_2001, 32'h0, 5'd5);
        check("lb_mem_be", {28'h0, mem_be}, 32'h2);
        check("lb_mem_we", {31'h0, mem_we}, 32'h0);
        mem_gnt = 1'b1;
        cyc();
        mem_gnt = 1'b0;
        check("lb_wait_no_req", {31'h0, mem_req}, 32'h0);
        check("lb_wait_no_resp", {31'h0, resp_valid}, 32'h0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000_8000;
        cyc();
        mem_rvalid = 1'b0;
        check("lb_resp_valid", {31'h0, resp_valid}, 32'h1);
        check("lb_resp_data", resp_data, 32'hFFFF_FF80);
        check("lb_resp_tag", {27'h0, resp_tag}, 32'd5);

        // LBU same access, gnt and rvalid together in REQ
        issue(1'b0, 3'b100, 32'h0000_2001, 32'h0, 5'd6);
        mem_gnt    = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000_8000;
        cyc();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        check("lbu_resp_valid", {31'h0, resp_valid}, 32'h1);
        check("lbu_resp_data", resp_data, 32'h0000_0080);
        check("lbu_ready", {31'h0, req_ready}, 32'h1);

        // Misaligned LW faults without a bus request
        issue(1'b0, 3'b010, 32'h0000_3002, 32'h0, 5'd7);
        check("lw_mis_mem_req", {31'h0, mem_req}, 32'h0);
        check("lw_mis_resp_valid", {31'h0, resp_valid}, 32'h1);
        check("lw_mis_fault", {31'h0, fault}, 32'h1);
        check("lw_mis_resp_data", resp_data, 32'h0);
        check("lw_mis_tag", {27'h0, resp_tag}, 32'd7);
        cyc();
        check("lw_mis_pulse_end", {31'h0, resp_valid}, 32'h0);

        // LH at 0x4002 with grant held off for 4 cycles
        issue(1'b0, 3'b001, 32'h0000_4002, 32'h0, 5'd9);
        for (int i = 0; i < 4; i++) begin
            check("lh_stall_mem_req", {31'h0, mem_req}, 32'h1);
            check("lh_stall_mem_addr", mem_addr, 32'h0000_4000);
            check("lh_stall_mem_be", {28'h0, mem_be}, 32'hC);
            check("lh_stall_ready", {31'h0, req_ready}, 32'h0);
            cyc();
        end
        mem_gnt    = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hBEEF_1234;
        cyc();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        check("lh_resp_data", resp_data, 32'hFFFF_BEEF);
        check("lh_resp_valid", {31'h0, resp_valid}, 32'h1);

        // SH at 0x5002
        issue(1'b1, 3'b001, 32'h0000_5002, 32'h1234_ABCD, 5'd10);
        check("sh_mem_be", {28'h0, mem_be}, 32'hC);
        check("sh_mem_wdata", mem_wdata, 32'hABCD_ABCD);
        mem_gnt = 1'b1;
        cyc();
        mem_gnt = 1'b0;
        check("sh_resp_valid", {31'h0, resp_valid}, 32'h1);

        // SW at 0x6000
        issue(1'b1, 3'b010, 32'h0000_6000, 32'hDEAD_BEEF, 5'd11);
        check("sw_mem_be", {28'h0, mem_be}, 32'hF);
        check("sw_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        mem_gnt = 1'b1;
        cyc();
        mem_gnt = 1'b0;

        // Illegal: store with funct3[2]=1, and load with funct3=011
        issue(1'b1, 3'b100, 32'h0000_6100, 32'h0, 5'd12);
        check("sbu_fault", {31'h0, fault}, 32'h1);
        check("sbu_no_req", {31'h0, mem_req}, 32'h0);
        issue(1'b0, 3'b011, 32'h0000_6200, 32'h0, 5'd13);
        check("f3_011_fault", {31'h0, fault}, 32'h1);
        check("f3_011_resp_valid", {31'h0, resp_valid}, 32'h1);

        // LHU at 0x7001 is misaligned
        issue(1'b0, 3'b101, 32'h0000_7001, 32'h0, 5'd14);
        check("lhu_mis_fault", {31'h0, fault}, 32'h1);

        // LW at 0x7000: rvalid without gnt in REQ is ignored
        issue(1'b0, 3'b010, 32'h0000_7000, 32'h0, 5'd15);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hCAFE_0000;
        cyc();
        mem_rvalid = 1'b0;
        check("lw_rvalid_nognt_resp", {31'h0, resp_valid}, 32'h0);
        check("lw_rvalid_nognt_req", {31'h0, mem_req}, 32'h1);
        mem_gnt = 1'b1;
        cyc();
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1122_3344;
        cyc();
        mem_rvalid = 1'b0;
        check("lw_resp_valid", {31'h0, resp_valid}, 32'h1);
        check("lw_resp_data", resp_data, 32'h1122_3344);
        check("lw_fault", {31'h0, fault}, 32'h0);

        // Reset while in WAIT, then stale rvalid
        issue(1'b0, 3'b101, 32'h0000_8000, 32'h0, 5'd16);
        mem_gnt = 1'b1;
        cyc();
        mem_gnt = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_ready", {31'h0, req_ready}, 32'h0);
        check("midrst_mem_req", {31'h0, mem_req}, 32'h0);
        cyc();
        rst_n      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0000_FFFF;
        cyc();
        mem_rvalid = 1'b0;
        check("midrst_ready_after", {31'h0, req_ready}, 32'h1);
        check("midrst_no_resp", {31'h0, resp_valid}, 32'h0);
        cyc();
        check("midrst_no_resp_late", {31'h0, resp_valid}, 32'h0);
        check("midrst_idle_no_req", {31'h0, mem_req}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
